disp_source_sel: RTL and testbench

//  Upstream feeder for the 4-digit seven-segment scanner: selects one of four
//  16-bit CPU debug values (PC, instruction, ALU result, memory data), registers
//  it and drives the scanner's 16-bit num input. A debounced push-button cycles
//  the source and a switch freezes the shown value. An optional BCD mode shows

---
 rtl/disp_source_sel.sv | 194 +++++++++++++++++++
 tb/tb_disp_source_sel.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_source_sel.sv
// Source selector for the 4-digit seven-segment scanner: a debounced button
// cycles among four 16-bit debug values; optional BCD conversion when DISP_BCD_EN is defined.
module disp_source_sel #(
  parameter int DEB_CNT = 50000,
  parameter int DEB_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        freeze,
  input  logic [15:0] pc,
  input  logic [15:0] instr,
  input  logic [15:0] alu_out,
  input  logic [15:0] mem_data,
  output logic [15:0] num,
  output logic [1:0]  sel,
  output logic        num_upd,
  output logic        ovf
);

  localparam int DATA_W = 16;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic              sync_p0, sync_p1;
  logic              deb_lvl;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_hit;
  logic              press;
  logic [DATA_W-1:0] src_mux;

  // ---- stage p0/p1: two-flop synchronizer for the raw button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_next;
      sync_p1 <= sync_p0;
    end
  end

  // A level change is accepted on the DEB_CNT-th consecutive differing cycle.
  assign deb_hit = (sync_p1 != deb_lvl) && (deb_cnt == DEB_LAST);
  assign press   = deb_hit && sync_p1;

  // ---- debouncer and source index
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
      sel     <= 2'd0;
    end else begin
      if (sync_p1 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_hit) begin
        deb_lvl <= sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (press) sel <= sel + 2'd1;
    end
  end

  always_comb begin
    src_mux = pc;
    case (sel)
      2'd0: src_mux = pc;
      2'd1: src_mux = instr;
      2'd2: src_mux = alu_out;
      2'd3: src_mux = mem_data;
      default: src_mux = pc;
    endcase
  end

`ifdef DISP_BCD_EN

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic              capture, load;
  logic [3:0]        shift_cnt;
  logic              discard;
  logic [DATA_W-1:0] bin_p0;
  logic [19:0]       bcd_p0;

  // One double-dabble step: add 3 to each low digit >= 5, then shift in a bit.
  // The fifth digit never exceeds 3 before the final shift for a 16-bit input.
  function automatic logic [19:0] dabble_step(input logic [18:0] bcd, input logic bit_in);
    logic [18:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return {adj, bit_in};
  endfunction

  function automatic logic [15:0] sat_bcd(input logic [19:0] bcd);
    return (bcd[19:16] != 4'd0) ? 16'h9999 : bcd[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!freeze) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        load = 1'b1;
        if (!freeze) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- conversion control: shift count and freeze-seen flag
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt <= 4'd0;
      discard   <= 1'b0;
    end else if (capture) begin
      shift_cnt <= 4'd0;
      discard   <= 1'b0;
    end else if (state == SHIFT) begin
      shift_cnt <= shift_cnt + 4'd1;
      if (freeze) discard <= 1'b1;
    end
  end

  // ---- conversion datapath
  always_ff @(posedge clk) begin
    if (capture) begin
      bin_p0 <= src_mux;
      bcd_p0 <= '0;
    end else if (state == SHIFT) begin
      bcd_p0 <= dabble_step(bcd_p0[18:0], bin_p0[DATA_W-1]);
      bin_p0 <= {bin_p0[DATA_W-2:0], 1'b0};
    end
  end

  // ---- output register: a result seen under freeze is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      num     <= '0;
      ovf     <= 1'b0;
      num_upd <= 1'b0;
    end else begin
      num_upd <= 1'b0;
      if (load && !discard && !freeze) begin
        num     <= sat_bcd(bcd_p0);
        ovf     <= (bcd_p0[19:16] != 4'd0);
        num_upd <= 1'b1;
      end
    end
  end

`else

  // ---- output register, hex path
  always_ff @(posedge clk) begin
    if (rst) begin
      num     <= '0;
      num_upd <= 1'b0;
    end else if (!freeze) begin
      num     <= src_mux;
      num_upd <= 1'b1;
    end else begin
      num_upd <= 1'b0;
    end
  end

  assign ovf = 1'b0;

`endif

endmodule

// File: tb/tb_disp_source_sel.sv
// Self-checking bench for disp_source_sel: directed steps plus randomized
// traffic compared every cycle against a behavioural model.
module tb_disp_source_sel;
  localparam int DEB = 4;

  logic        clk;
  logic        rst;
  logic        btn_next;
  logic        freeze;
  logic [15:0] pc, instr, alu_out, mem_data;
  logic [15:0] num;
  logic [1:0]  sel;
  logic        num_upd;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  disp_source_sel #(.DEB_CNT(DEB), .DEB_W(16)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .freeze(freeze),
    .pc(pc), .instr(instr), .alu_out(alu_out), .mem_data(mem_data),
    .num(num), .sel(sel), .num_upd(num_upd), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  bit          hist[$];
  int          m_run = 0;
  bit          m_lvl = 0;
  int          m_sel = 0;
  logic [15:0] m_num = 0;
  bit          m_upd = 0;
  bit          m_ovf = 0;
  int          m_left = 0;
  bit          m_disc = 0;
  int          m_op = 0;

  function automatic logic [15:0] pick(input int s);
    case (s)
      0: return pc;
      1: return instr;
      2: return alu_out;
      default: return mem_data;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    bit synced;
    if (rst) begin
      hist = {1'b0, 1'b0};
      m_run = 0; m_lvl = 0; m_sel = 0; m_num = 0; m_upd = 0; m_ovf = 0;
      m_left = 0; m_disc = 0;
    end else begin
      synced = hist.pop_front();
      hist.push_back(btn_next);
`ifdef DISP_BCD_EN
      m_upd = 0;
      if (m_left > 0) begin
        m_left--;
        if (freeze) m_disc = 1;
        if (m_left == 0) begin
          if (!m_disc) begin
            m_ovf = (m_op > 9999);
            m_num = m_ovf ? 16'h9999 : to_bcd(m_op);
            m_upd = 1;
          end
          if (!freeze) begin
            m_op = int'(pick(m_sel)); m_left = 17; m_disc = 0;
          end
        end
      end else if (!freeze) begin
        m_op = int'(pick(m_sel)); m_left = 17; m_disc = 0;
      end
`else
      if (!freeze) begin
        m_num = pick(m_sel);
        m_upd = 1;
      end else begin
        m_upd = 0;
      end
`endif
      if (synced != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = synced;
          m_run = 0;
          if (m_lvl) m_sel = (m_sel + 1) % 4;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("model_num", {16'd0, num}, {16'd0, m_num});
    chk("model_sel", {30'd0, sel}, m_sel);
    chk("model_upd", {31'd0, num_upd}, {31'd0, m_upd});
    chk("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    chk("rst_num", {16'd0, num}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_upd", {31'd0, num_upd}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic press();
    btn_next = 1'b1;
    repeat (8) cyc();
  endtask

  task automatic release_btn();
    btn_next = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    int n;
    rst = 1'b1; btn_next = 1'b0; freeze = 1'b0;
    pc = 16'h1111; instr = 16'h2222; alu_out = 16'h3333; mem_data = 16'h4444;
    @(negedge clk);

    // Reset with nonzero sources
    do_reset();

    // Bouncing button: only the steady hold advances sel
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      repeat (2) cyc();
    end
    chk("bounce_sel", {30'd0, sel}, 32'd0);
    btn_next = 1'b1;
    repeat (10) cyc();
    chk("deb_sel", {30'd0, sel}, 32'd1);
    release_btn();
    chk("release_sel", {30'd0, sel}, 32'd1);

`ifndef DISP_BCD_EN
    // Four clean presses walk through all sources
    do_reset();
    pc = 16'h1234; instr = 16'hABCD; alu_out = 16'h0042; mem_data = 16'hBEEF;
    press(); chk("p1_sel", {30'd0, sel}, 32'd1); chk("p1_num", {16'd0, num}, 32'hABCD); release_btn();
    press(); chk("p2_sel", {30'd0, sel}, 32'd2); chk("p2_num", {16'd0, num}, 32'h0042); release_btn();
    press(); chk("p3_sel", {30'd0, sel}, 32'd3); chk("p3_num", {16'd0, num}, 32'hBEEF); release_btn();
    press(); chk("p4_sel", {30'd0, sel}, 32'd0); chk("p4_num", {16'd0, num}, 32'h1234); release_btn();

    // Freeze holds num; release reloads on the next edge
    freeze = 1'b1; pc = 16'h5678;
    cyc();
    chk("frz_num", {16'd0, num}, 32'h1234);
    chk("frz_upd", {31'd0, num_upd}, 32'd0);
    cyc();
    chk("frz_num2", {16'd0, num}, 32'h1234);
    freeze = 1'b0;
    cyc();
    chk("unfrz_num", {16'd0, num}, 32'h5678);
    chk("unfrz_upd", {31'd0, num_upd}, 32'd1);
`else
    // Conversion latency and saturation
    btn_next = 1'b0;
    pc = 16'd1234;
    do_reset();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (num_upd) begin n = i; break; end
    end
    chk("bcd_lat", n, 32'd18);
    chk("bcd_num", {16'd0, num}, 32'h1234);
    chk("bcd_ovf", {31'd0, ovf}, 32'd0);
    pc = 16'd65535;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (num_upd && num == 16'h9999) begin n = i; break; end
    end
    chk("sat_seen", {31'd0, (n != 0)}, 32'd1);
    chk("sat_ovf", {31'd0, ovf}, 32'd1);

    // Reset in the middle of a conversion, then a full-length conversion
    pc = 16'd4321;
    repeat (9) cyc();
    do_reset();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (num_upd) begin n = i; break; end
    end
    chk("abort_lat", n, 32'd18);
    chk("abort_num", {16'd0, num}, 32'h4321);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) btn_next = ~btn_next;
      freeze = ($urandom_range(9) == 0);
      rst = ($urandom_range(149) == 0);
      pc = 16'($urandom); instr = 16'($urandom);
      alu_out = 16'($urandom); mem_data = 16'($urandom);
      cyc();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
